// File: rtl/instruction_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : instruction_fetch_unit
// Description : Fetch stage for the pipelined core. Holds the program
//               counter and issues one sequential request per cycle to a
//               synchronous, latency-1 instruction memory. Returned words
//               are buffered with their PCs in a circular fetch queue and
//               offered to decode over a valid/ready handshake. A redirect
//               reloads the PC, flushes the queue and discards the
//               in-flight response.
// Ports       :
//   clk            - rising-edge clock
//   reset          - asynchronous, active-low reset
//   imem_req       - fetch request strobe this cycle
//   imem_addr      - fetch address (always equals fetch_pc)
//   imem_rdata     - instruction word, valid the cycle after a request
//   redirect_valid - load redirect_pc and flush fetch state
//   redirect_pc    - redirect target, bits [1:0] forced to 0
//   if_valid       - queue head valid to decode
//   if_ready       - decode accepts the head this cycle
//   if_pc          - PC of the head entry
//   if_instr       - instruction of the head entry
// Revision    : 1.0 - initial release
// ============================================================================
module instruction_fetch_unit #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              FQ_DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] if_instr
);

  localparam int CW = $clog2(FQ_DEPTH + 1);
  localparam int PW = $clog2(FQ_DEPTH);

  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] req_pc;     // PC of the request now in flight
  logic            inflight;
  logic            drop;
  logic [CW-1:0]   count;
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic [XLEN-1:0] fq_pc    [FQ_DEPTH];
  logic [XLEN-1:0] fq_instr [FQ_DEPTH];

  logic [CW:0]     occupancy;
  logic            push;
  logic            pop;

  // Slots already committed: stored entries plus the response still on its
  // way. Only registered count is used, so a pop this cycle gives no credit.
  assign occupancy = {1'b0, count} + {{CW{1'b0}}, inflight};

  assign imem_req  = reset & ~redirect_valid & (occupancy < (CW+1)'(FQ_DEPTH));
  assign imem_addr = fetch_pc;

  assign if_valid  = (count != '0);
  assign if_pc     = fq_pc[rd_ptr];
  assign if_instr  = fq_instr[rd_ptr];

  // A redirect discards both the arriving response and the head pop.
  assign push = inflight & ~drop & ~redirect_valid;
  assign pop  = if_valid & if_ready & ~redirect_valid;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc <= RESET_PC;
      req_pc   <= RESET_PC;
      inflight <= 1'b0;
      drop     <= 1'b0;
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
    end else begin
      inflight <= imem_req;
      if (imem_req) begin
        req_pc <= fetch_pc;
      end

      if (redirect_valid) begin
        fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00};
        drop     <= inflight;
        count    <= '0;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
      end else begin
        drop <= 1'b0;
        if (imem_req) begin
          fetch_pc <= fetch_pc + XLEN'(4);
        end
        if (push) begin
          wr_ptr <= wr_ptr + PW'(1);
        end
        if (pop) begin
          rd_ptr <= rd_ptr + PW'(1);
        end
        case ({push, pop})
          2'b10:   count <= count + CW'(1);
          2'b01:   count <= count - CW'(1);
          default: count <= count;
        endcase
      end
    end
  end

  // Queue storage carries no reset; entries are only observed once counted.
  always_ff @(posedge clk) begin
    if (push) begin
      fq_pc[wr_ptr]    <= req_pc;
      fq_instr[wr_ptr] <= imem_rdata;
    end
  end

endmodule
`default_nettype wire
